// File: rtl/fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_enq_arbiter
// Brief    : Round-robin arbiter sharing one FIFO enqueue port among N_REQ
//            requesters, holding a stalled grant until it transfers.
// Revision : 1.0
// ============================================================================
module fifo_enq_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ENTRY_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_aL,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*ENTRY_WIDTH-1:0] req_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ENTRY_WIDTH-1:0]       out_data,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic [7:0]                   stall_count
);

    localparam int ID_WIDTH = $clog2(N_REQ);

    logic [ID_WIDTH-1:0] prio_ptr_q,    prio_ptr_d;
    logic                locked_q,      locked_d;
    logic [ID_WIDTH-1:0] lock_id_q,     lock_id_d;
    logic [7:0]          stall_count_q, stall_count_d;

    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] rr_id;
    logic                rr_found;
    logic [ID_WIDTH-1:0] sel_id;
    logic                xfer;
    logic                stall;

    // Round-robin scan starting just after the last-served requester.
    always_comb begin
        scan_idx = '0;
        rr_id    = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = ID_WIDTH'((int'(prio_ptr_q) + k) % N_REQ);
            if (!rr_found && req_valid[scan_idx]) begin
                rr_id    = scan_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_id    = locked_q ? lock_id_q : rr_id;
        out_valid = locked_q ? req_valid[lock_id_q] : (|req_valid);
        out_data  = req_data[int'(sel_id)*ENTRY_WIDTH +: ENTRY_WIDTH];
        grant_id  = out_valid ? sel_id : '0;
        xfer      = out_valid & out_ready;
        stall     = out_valid & ~out_ready;
        req_ready = xfer ? (N_REQ'(1) << sel_id) : '0;
    end

    always_comb begin
        prio_ptr_d    = prio_ptr_q;
        locked_d      = locked_q;
        lock_id_d     = lock_id_q;
        stall_count_d = stall_count_q;
        if (xfer) begin
            prio_ptr_d = sel_id;
            locked_d   = 1'b0;
        end else if (stall) begin
            locked_d  = 1'b1;
            lock_id_d = sel_id;
        end else begin
            // A locked requester that withdrew its request releases the lock.
            locked_d = 1'b0;
        end
        if (stall && (stall_count_q != 8'hFF)) begin
            stall_count_d = stall_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            prio_ptr_q    <= ID_WIDTH'(N_REQ - 1);
            locked_q      <= 1'b0;
            lock_id_q     <= '0;
            stall_count_q <= '0;
        end else begin
            prio_ptr_q    <= prio_ptr_d;
            locked_q      <= locked_d;
            lock_id_q     <= lock_id_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire
